// File: rtl/svc_stats_readout.sv
// svc_stats_readout: snapshot NUM_STATS stat values on request, optionally clear
// the upstream collectors in the same cycle, then stream the snapshot out as
// OUT_WIDTH-wide words (least-significant word first) over valid/ready.
module svc_stats_readout #(
  parameter int NUM_STATS     = 4,
  parameter int STAT_WIDTH    = 32,
  parameter int OUT_WIDTH     = 8,
  parameter int CLEAR_ON_SNAP = 1,
  parameter int IDX_WIDTH     = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            snap_valid,
  output logic                            snap_ready,
  input  logic [NUM_STATS*STAT_WIDTH-1:0] stats,
  output logic                            stat_clr,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [OUT_WIDTH-1:0]            m_data,
  output logic [IDX_WIDTH-1:0]            m_idx,
  output logic                            m_last
);

  localparam int WPS = STAT_WIDTH / OUT_WIDTH;
  localparam int WCW = (WPS > 1) ? $clog2(WPS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  if ((STAT_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
    $error("svc_stats_readout: STAT_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic [0:0]            state_q, state_d;
  logic [IDX_WIDTH-1:0]  stat_cnt_q, stat_cnt_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [STAT_WIDTH-1:0] shadow_q [NUM_STATS];

  logic                  capture;
  logic                  word_wrap;
  logic                  stat_end;
  logic [STAT_WIDTH-1:0] sel_stat;

  // Handshake flags and end-of-word / end-of-snapshot detection
  always_comb begin
    snap_ready = (state_q == ST_IDLE);
    m_valid    = (state_q == ST_SEND);
    capture    = snap_valid && snap_ready;
    word_wrap  = (word_cnt_q == WCW'(WPS - 1));
    stat_end   = (stat_cnt_q == IDX_WIDTH'(NUM_STATS - 1));
    m_last     = m_valid && word_wrap && stat_end;
    m_idx      = stat_cnt_q;
  end

  if (CLEAR_ON_SNAP != 0) begin : g_clr
    assign stat_clr = capture;
  end else begin : g_no_clr
    assign stat_clr = 1'b0;
  end

  // Select the current stat from the shadow bank, then the current word within it
  always_comb begin
    sel_stat = '0;
    for (int unsigned i = 0; i < NUM_STATS; i++) begin
      if (stat_cnt_q == IDX_WIDTH'(i)) sel_stat = shadow_q[i];
    end
    m_data = '0;
    for (int unsigned w = 0; w < WPS; w++) begin
      if (word_cnt_q == WCW'(w)) m_data = sel_stat[w*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // Next-state: start a stream on capture, advance word/stat counters on each accepted beat
  always_comb begin
    state_d    = state_q;
    stat_cnt_d = stat_cnt_q;
    word_cnt_d = word_cnt_q;
    if (capture) begin
      state_d    = ST_SEND;
      stat_cnt_d = '0;
      word_cnt_d = '0;
    end else if (m_valid && m_ready) begin
      if (word_wrap) begin
        word_cnt_d = '0;
        if (stat_end) begin
          state_d    = ST_IDLE;
          stat_cnt_d = '0;
        end else begin
          stat_cnt_d = stat_cnt_q + 1'b1;
        end
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stat_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stat_cnt_q <= stat_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Shadow bank: loaded on the same edge that clears the collectors, so no update is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STATS; i++) shadow_q[i] <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_STATS; i++) begin
        shadow_q[i] <= stats[i*STAT_WIDTH +: STAT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_svc_stats_readout.sv
// Self-checking bench for svc_stats_readout: directed scenarios plus random
// snapshot/backpressure/reset traffic against a queue-based beat model.
module tb_svc_stats_readout;

  localparam int NS  = 2;
  localparam int SW  = 32;
  localparam int OW  = 16;
  localparam int WPS = SW / OW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 x 32-bit stats, 16-bit words, clear enabled
  logic             rst;
  logic             snap_valid;
  logic             snap_ready;
  logic [NS*SW-1:0] stats;
  logic             stat_clr;
  logic             m_valid;
  logic             m_ready;
  logic [OW-1:0]    m_data;
  logic [0:0]       m_idx;
  logic             m_last;

  // Instance B: single 8-bit stat, one word, clear disabled
  logic       b_snap_valid;
  logic       b_snap_ready;
  logic [7:0] b_stats;
  logic       b_stat_clr;
  logic       b_m_valid;
  logic       b_m_ready;
  logic [7:0] b_m_data;
  logic [0:0] b_m_idx;
  logic       b_m_last;

  svc_stats_readout #(
    .NUM_STATS(NS), .STAT_WIDTH(SW), .OUT_WIDTH(OW), .CLEAR_ON_SNAP(1)
  ) dut_a (
    .clk(clk), .rst(rst), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .stats(stats), .stat_clr(stat_clr), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
  );

  svc_stats_readout #(
    .NUM_STATS(1), .STAT_WIDTH(8), .OUT_WIDTH(8), .CLEAR_ON_SNAP(0)
  ) dut_b (
    .clk(clk), .rst(rst), .snap_valid(b_snap_valid), .snap_ready(b_snap_ready),
    .stats(b_stats), .stat_clr(b_stat_clr), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_data(b_m_data), .m_idx(b_m_idx), .m_last(b_m_last)
  );

  typedef struct {
    logic [OW-1:0] data;
    int unsigned   idx;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  bit    busy;
  bit    just_reset;
  int    checks;
  int    errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance A: drive inputs, check at the falling edge,
  // update the model, then return just after the next rising edge.
  task automatic step(input logic sv, input logic mr, input logic r);
    beat_t b;
    snap_valid = sv;
    m_ready    = mr;
    rst        = r;
    @(negedge clk);
    chk("b_stat_clr", b_stat_clr, 0);
    if (r) begin
      busy = 0;
      exp_q.delete();
      just_reset = 1;
    end else if (!busy) begin
      chk("snap_ready_idle", snap_ready, 1);
      chk("m_valid_idle", m_valid, 0);
      chk("stat_clr_idle", stat_clr, sv);
      if (just_reset) begin
        chk("rst_m_data", m_data, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_m_last", m_last, 0);
      end
      if (sv) begin
        for (int s = 0; s < NS; s++) begin
          for (int w = 0; w < WPS; w++) begin
            b.data = OW'(stats >> (s*SW + w*OW));
            b.idx  = s;
            b.last = (s == NS-1) && (w == WPS-1);
            exp_q.push_back(b);
          end
        end
        busy = 1;
      end
      just_reset = 0;
    end else begin
      b = exp_q[0];
      chk("snap_ready_send", snap_ready, 0);
      chk("m_valid_send", m_valid, 1);
      chk("stat_clr_send", stat_clr, 0);
      chk("m_data", m_data, b.data);
      chk("m_idx", m_idx, b.idx);
      chk("m_last", m_last, b.last);
      if (mr) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] pat;
    checks = 0;
    errors = 0;
    busy = 0;
    just_reset = 0;
    snap_valid = 0; m_ready = 0; rst = 1; stats = '0;
    b_snap_valid = 0; b_m_ready = 0; b_stats = '0;
    @(posedge clk); #1;
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // Scenario 6: one 8-bit stat, no upstream clear, single last beat
    b_stats = 8'hA5;
    b_snap_valid = 1;
    step(0, 0, 0);
    b_snap_valid = 0;
    chk("b_m_valid", b_m_valid, 1);
    chk("b_snap_ready_send", b_snap_ready, 0);
    chk("b_m_data", b_m_data, 8'hA5);
    chk("b_m_idx", b_m_idx, 0);
    chk("b_m_last", b_m_last, 1);
    b_m_ready = 1;
    step(0, 0, 0);
    b_m_ready = 0;
    chk("b_m_valid_done", b_m_valid, 0);
    chk("b_snap_ready_done", b_snap_ready, 1);

    // Scenario 1: one-cycle request, downstream always ready
    stats = {32'h3333_4444, 32'h1111_2222};
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("s1_ready_after_last", snap_ready, 1);
    step(0, 1, 0);

    // Scenario 2: backpressure pattern 1,0,0,1,0,1,1
    step(1, 1, 0);
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) step(0, pat[i], 0);
    step(0, 1, 0);

    // Scenario 3: stats change right after capture
    stats = {32'h3333_4444, 32'h1111_2222};
    step(1, 1, 0);
    stats = '1;
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 0);

    // Scenario 4: request held through SEND, re-accepted in first idle cycle
    stats = {32'hDEAD_BEEF, 32'hCAFE_F00D};
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 0);

    // Scenario 5: reset after two beats, then a fresh snapshot
    stats = {32'h0123_4567, 32'h89AB_CDEF};
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    stats = {32'h5555_6666, 32'h7777_8888};
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 0, 0);

    // Random traffic: requests, backpressure, stat churn, occasional reset
    for (int i = 0; i < 400; i++) begin
      stats = {$urandom, $urandom};
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 80) == 0);
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
